sync_fifo_param: RTL and testbench

- Parametrised single-clock FIFO; next generation of the team's 16x8 sync FIFO.
- Generalised WIDTH/DEPTH, fill-level count, programmable almost-full/almost-empty flags, pass-through read+write when full, per-cycle error pulses, optional first-word-fall-through read mode.
- Sits between producer/consumer blocks in one clock domain; drop-in for the old FIFO port set plus new status outputs.

---
 rtl/sync_fifo_param_if.sv | 45 ++++
 rtl/sync_fifo_param.sv | 165 ++++++++++++++++
 tb/tb_sync_fifo_param.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// Bundled data/status signals of the parametrised single-clock FIFO.
// The producer/consumer side connects through the master modport and the
// FIFO through the slave modport. The signal names match the port set of
// the earlier 16x8 FIFO so existing users can be rewired one-to-one.
//
// Handshake rules (one clock domain, every transfer on the rising edge):
//   write: wr_en_i is the valid. The word on wdata_i is taken at an edge
//          where wr_en_i=1 and either full_o=0 or a read is accepted at the
//          same edge. Otherwise the word is dropped and wr_error_o pulses for
//          the following cycle.
//   read:  rd_en_i is the request (an acknowledge in first-word-fall-through
//          builds). A read is taken at an edge where rd_en_i=1 and
//          empty_o=0. Otherwise rd_error_o pulses for the following cycle.
//   All status outputs are registered and describe the state after the most
//   recent edge.
interface sync_fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [WIDTH-1:0]   wdata_i;
  logic               wr_en_i;
  logic               full_o;
  logic               wr_error_o;
  logic               rd_en_i;
  logic [WIDTH-1:0]   rdata_o;
  logic               empty_o;
  logic               rd_error_o;
  logic [PTR_WIDTH:0] count_o;
  logic               almost_full_o;
  logic               almost_empty_o;

  modport master (
    output wdata_i, wr_en_i, rd_en_i,
    input  full_o, wr_error_o, rdata_o, empty_o, rd_error_o,
           count_o, almost_full_o, almost_empty_o
  );

  modport slave (
    input  wdata_i, wr_en_i, rd_en_i,
    output full_o, wr_error_o, rdata_o, empty_o, rd_error_o,
           count_o, almost_full_o, almost_empty_o
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill-level count, programmable
// almost-full / almost-empty flags, write-while-full pass-through (when a
// read is accepted at the same edge) and one-cycle error pulses for
// rejected requests.
//
// Optional build macro: SYNC_FIFO_FWFT_EN
//   defined   -> first-word-fall-through: rdata_o shows the head word
//                combinationally whenever empty_o=0, rd_en_i pops it.
//   undefined -> standard mode: rdata_o is registered and updates one cycle
//                after an accepted read, holding its value otherwise.
//
// The bus interface instance must be created with the same WIDTH and DEPTH
// as this module.
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int PTR_WIDTH = $clog2(DEPTH),
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 2
) (
  input logic              clk_i,
  input logic              rst_i,
  sync_fifo_param_if.slave bus
);

  // Threshold constants sized to the count so the flag compares are exact.
  localparam logic [PTR_WIDTH:0] AF_C  = (PTR_WIDTH + 1)'(AF_THRESH);
  localparam logic [PTR_WIDTH:0] AE_C  = (PTR_WIDTH + 1)'(AE_THRESH);
  localparam logic [PTR_WIDTH:0] ONE_C = (PTR_WIDTH + 1)'(1);

  // Storage; contents are deliberately not cleared by reset.
  logic [WIDTH-1:0] mem [DEPTH];

  // Pointers carry one wrap bit above the address bits so that full and
  // empty can be told apart when the addresses match.
  logic [PTR_WIDTH:0]   wr_ptr;
  logic [PTR_WIDTH:0]   rd_ptr;
  logic [PTR_WIDTH:0]   wr_ptr_next;
  logic [PTR_WIDTH:0]   rd_ptr_next;
  logic [PTR_WIDTH-1:0] wr_addr;
  logic [PTR_WIDTH-1:0] rd_addr;

  logic [PTR_WIDTH:0] count;
  logic [PTR_WIDTH:0] count_next;

  logic full_q;
  logic empty_q;
  logic af_q;
  logic ae_q;
  logic wr_err_q;
  logic rd_err_q;

  logic full_next;
  logic empty_next;
  logic af_next;
  logic ae_next;

  logic rd_acc;
  logic wr_acc;
  logic wr_rej;
  logic rd_rej;

  assign wr_addr = wr_ptr[PTR_WIDTH-1:0];
  assign rd_addr = rd_ptr[PTR_WIDTH-1:0];

  // Request acceptance: a read needs a stored word; a write needs a free
  // slot, or a slot being vacated by a read accepted at the same edge.
  always_comb begin
    rd_acc = bus.rd_en_i & ~empty_q;
    wr_acc = bus.wr_en_i & (~full_q | rd_acc);
    wr_rej = bus.wr_en_i & ~wr_acc;
    rd_rej = bus.rd_en_i & ~rd_acc;
  end

  // Next pointers, occupancy and registered-flag values.
  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count;
    if (wr_acc) begin
      wr_ptr_next = wr_ptr + ONE_C;
    end
    if (rd_acc) begin
      rd_ptr_next = rd_ptr + ONE_C;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count + ONE_C;
      2'b01:   count_next = count - ONE_C;
      default: count_next = count;
    endcase
    empty_next = (wr_ptr_next == rd_ptr_next);
    full_next  = (wr_ptr_next[PTR_WIDTH-1:0] == rd_ptr_next[PTR_WIDTH-1:0]) &&
                 (wr_ptr_next[PTR_WIDTH] != rd_ptr_next[PTR_WIDTH]);
    af_next    = (count_next >= AF_C);
    ae_next    = (count_next <= AE_C);
  end

  // Memory write port; a write while full lands in the slot the
  // simultaneous read is vacating (the read still sees the old word).
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem[wr_addr] <= bus.wdata_i;
    end
  end

  // Pointer, count, flag and error-pulse registers; reset overrides any
  // request presented in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_next;
      rd_ptr   <= rd_ptr_next;
      count    <= count_next;
      full_q   <= full_next;
      empty_q  <= empty_next;
      af_q     <= af_next;
      ae_q     <= ae_next;
      wr_err_q <= wr_rej;
      rd_err_q <= rd_rej;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word falls through whenever something is stored; forced to zero
  // while empty so the value after reset is clean.
  always_comb begin
    bus.rdata_o = '0;
    if (!empty_q) begin
      bus.rdata_o = mem[rd_addr];
    end
  end
`else
  logic [WIDTH-1:0] rdata_q;

  // Registered read data: loads the head word on an accepted read and
  // otherwise holds the last word returned.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rdata_q <= '0;
    end else if (rd_acc) begin
      rdata_q <= mem[rd_addr];
    end
  end

  assign bus.rdata_o = rdata_q;
`endif

  assign bus.full_o         = full_q;
  assign bus.empty_o        = empty_q;
  assign bus.almost_full_o  = af_q;
  assign bus.almost_empty_o = ae_q;
  assign bus.wr_error_o     = wr_err_q;
  assign bus.rd_error_o     = rd_err_q;
  assign bus.count_o        = count;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DEPTH=16, WIDTH=8, AF=12, AE=2).
// A table of one-cycle vectors covers fill, overflow, write-while-full,
// drain and underflow; hand-written sequences cover pointer wrap with a
// mid-burst reset and, in fall-through builds, the FWFT head behaviour.
module tb_sync_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sync_fifo_param #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_THRESH(AF),
    .AE_THRESH(AE)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );

  // ---------------- scoreboard counters ----------------
  int checks;
  int errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // All status outputs against a hand-supplied occupancy; the flags follow
  // from the thresholds of this configuration.
  task automatic chk_status(input string tag, input int cnt, input logic werr, input logic rerr);
    chk({tag, " count"},   32'(bus.count_o),        32'(cnt));
    chk({tag, " full"},    32'(bus.full_o),         32'(cnt == DEPTH));
    chk({tag, " empty"},   32'(bus.empty_o),        32'(cnt == 0));
    chk({tag, " a_full"},  32'(bus.almost_full_o),  32'(cnt >= AF));
    chk({tag, " a_empty"}, 32'(bus.almost_empty_o), 32'(cnt <= AE));
    chk({tag, " wr_err"},  32'(bus.wr_error_o),     32'(werr));
    chk({tag, " rd_err"},  32'(bus.rd_error_o),     32'(rerr));
  endtask

  // ---------------- driver ----------------
  // One clock cycle with the given requests; returns #1 after the edge.
  task automatic step(input logic wr, input logic rd, input logic [WIDTH-1:0] wd);
    bus.wr_en_i = wr;
    bus.rd_en_i = rd;
    bus.wdata_i = wd;
    @(posedge clk);
    #1;
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] wd;
    int               cnt;
    logic             werr;
    logic             rerr;
    logic             chk_rd;
    logic [WIDTH-1:0] rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic wr, input logic rd, input logic [WIDTH-1:0] wd,
                              input int cnt, input logic werr, input logic rerr,
                              input logic chk_rd, input logic [WIDTH-1:0] rdata);
    vec_t v;
    v.wr = wr; v.rd = rd; v.wd = wd; v.cnt = cnt;
    v.werr = werr; v.rerr = rerr; v.chk_rd = chk_rd; v.rdata = rdata;
    return v;
  endfunction

  logic [WIDTH-1:0] exp_q[$];

  initial begin
    checks = 0;
    errors = 0;
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    bus.wdata_i = '0;

    // Fill 0x01..0x10.
    for (int k = 1; k <= 16; k++)
      vecs.push_back(mk(1'b1, 1'b0, WIDTH'(k), k, 1'b0, 1'b0, 1'b0, '0));
    // Overflow attempt, then the pulse must have dropped.
    vecs.push_back(mk(1'b1, 1'b0, 8'hAA, 16, 1'b1, 1'b0, 1'b0, '0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 16, 1'b0, 1'b0, 1'b0, '0));
    // Write while full with a read: oldest word out, still full.
    vecs.push_back(mk(1'b1, 1'b1, 8'h55, 16, 1'b0, 1'b0, 1'b1, 8'h01));
    // Drain: 0x02..0x10 then 0x55.
    for (int j = 1; j <= 16; j++)
      vecs.push_back(mk(1'b0, 1'b1, 8'h00, 16 - j, 1'b0, 1'b0, 1'b1,
                        (j == 16) ? 8'h55 : WIDTH'(j + 1)));
    // Underflow, pulse drop, empty write+read, then read back.
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b1, 8'h55));
    vecs.push_back(mk(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1, 8'h55));
    vecs.push_back(mk(1'b1, 1'b1, 8'h77, 1, 1'b0, 1'b1, 1'b1, 8'h55));
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b1, 8'h77));

    // Reset and its output values.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_status("reset", 0, 1'b0, 1'b0);
    chk("reset rdata", 32'(bus.rdata_o), 32'h0);
    rst_n = 1'b1;

    // Table-driven phase.
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].wd);
      chk_status($sformatf("v%0d", i), vecs[i].cnt, vecs[i].werr, vecs[i].rerr);
`ifndef SYNC_FIFO_FWFT_EN
      if (vecs[i].chk_rd)
        chk($sformatf("v%0d rdata", i), 32'(bus.rdata_o), 32'(vecs[i].rdata));
`endif
    end

    // Pointer wrap: 16 writes, 13 reads, 4 writes -> 7 stored.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, WIDTH'(8'h80 + i));
      exp_q.push_back(WIDTH'(8'h80 + i));
    end
    for (int i = 0; i < 13; i++) begin
      logic [WIDTH-1:0] e;
      e = exp_q.pop_front();
`ifdef SYNC_FIFO_FWFT_EN
      chk($sformatf("wrap head %0d", i), 32'(bus.rdata_o), 32'(e));
      step(1'b0, 1'b1, '0);
`else
      step(1'b0, 1'b1, '0);
      chk($sformatf("wrap rd %0d", i), 32'(bus.rdata_o), 32'(e));
`endif
    end
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, WIDTH'(8'h90 + i));
    chk_status("wrap fill", 7, 1'b0, 1'b0);

    // Reset mid-burst with both requests active: reset wins.
    rst_n = 1'b0;
    step(1'b1, 1'b1, 8'hEE);
    rst_n = 1'b1;
    chk_status("mid rst", 0, 1'b0, 1'b0);
    chk("mid rst rdata", 32'(bus.rdata_o), 32'h0);

    // Life after reset: 0x3C in and out.
    step(1'b1, 1'b0, 8'h3C);
    chk_status("post wr", 1, 1'b0, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("post head", 32'(bus.rdata_o), 32'h3C);
    step(1'b0, 1'b1, '0);
`else
    step(1'b0, 1'b1, '0);
    chk("post rd", 32'(bus.rdata_o), 32'h3C);
`endif
    chk_status("post drain", 0, 1'b0, 1'b0);

`ifdef SYNC_FIFO_FWFT_EN
    // Fall-through: head visible without a request, next word right after pop.
    step(1'b1, 1'b0, 8'h11);
    chk("fwft head1", 32'(bus.rdata_o), 32'h11);
    step(1'b1, 1'b0, 8'h22);
    step(1'b0, 1'b0, '0);
    chk("fwft hold", 32'(bus.rdata_o), 32'h11);
    chk_status("fwft two", 2, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0);
    chk("fwft pop", 32'(bus.rdata_o), 32'h22);
    chk_status("fwft one", 1, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0);
    chk_status("fwft empty", 0, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
